// File: rtl/spmv_sram_arbiter.sv
// Round-robin, burst-granular arbiter sharing one single-port SRAM bank among NREQ
// requesters, with 1-cycle read-data routing back to the requester that issued the read.
module spmv_sram_arbiter #(
    parameter int NREQ      = 3,
    parameter int AW        = 5,
    parameter int DW        = 256,
    parameter int MAX_BURST = 8
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic [NREQ-1:0]    i_req,
    input  logic [NREQ-1:0]    i_last,
    input  logic [NREQ-1:0]    i_wr_en,
    input  logic [NREQ*AW-1:0] i_addr,
    input  logic [NREQ*DW-1:0] i_wdata,
    output logic [NREQ-1:0]    o_gnt,
    output logic [AW-1:0]      o_address,
    output logic               o_wr_en,
    output logic [DW-1:0]      o_write_data,
    input  logic [DW-1:0]      i_read_data,
    output logic [NREQ-1:0]    o_rvalid,
    output logic [DW-1:0]      o_rdata,
    output logic               o_busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(MAX_BURST + 1);

    localparam logic [0:0]    S_IDLE   = 1'b0;
    localparam logic [0:0]    S_GRANT  = 1'b1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);
    localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_BURST);

    logic [AW-1:0] addr_arr  [NREQ];
    logic [DW-1:0] wdata_arr [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = i_addr[gi*AW +: AW];
            assign wdata_arr[gi] = i_wdata[gi*DW +: DW];
        end
    endgenerate

    logic [0:0]      state_reg,    state_next;
    logic [IW-1:0]   owner_reg,    owner_next;
    logic [IW-1:0]   rr_ptr_reg,   rr_ptr_next;
    logic [NREQ-1:0] gnt_reg,      gnt_next;
    logic [NREQ-1:0] rvalid_reg,   rvalid_next;
    logic [CW-1:0]   beat_cnt_reg, beat_cnt_next;

    logic            own_req;
    logic            own_last;
    logic            own_wr;
    logic [AW-1:0]   own_addr;
    logic [DW-1:0]   own_wdata;
    logic            beat;
    logic [CW-1:0]   cnt_inc;
    logic            found;
    logic [IW-1:0]   winner;
    logic [IW:0]     cand_sum;

    always_comb begin
        own_req   = i_req[owner_reg];
        own_last  = i_last[owner_reg];
        own_wr    = i_wr_en[owner_reg];
        own_addr  = addr_arr[owner_reg];
        own_wdata = wdata_arr[owner_reg];
        beat      = (state_reg == S_GRANT) && own_req;
        cnt_inc   = beat_cnt_reg + CW'(1);
    end

    // SRAM side is combinational so an async reset (state -> IDLE) kills a write at once.
    assign o_address    = beat ? own_addr  : '0;
    assign o_wr_en      = beat ? own_wr    : 1'b0;
    assign o_write_data = beat ? own_wdata : '0;
    assign o_gnt        = gnt_reg;
    assign o_rvalid     = rvalid_reg;
    assign o_rdata      = i_read_data;
    assign o_busy       = (state_reg == S_GRANT);

    // First requester at or above the rr pointer, wrapping past NREQ-1 back to 0.
    always_comb begin
        found    = 1'b0;
        winner   = rr_ptr_reg;
        cand_sum = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand_sum = {1'b0, rr_ptr_reg} + (IW+1)'(i);
            if (cand_sum >= (IW+1)'(NREQ)) begin
                cand_sum = cand_sum - (IW+1)'(NREQ);
            end
            if (!found && i_req[cand_sum[IW-1:0]]) begin
                found  = 1'b1;
                winner = cand_sum[IW-1:0];
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        owner_next    = owner_reg;
        rr_ptr_next   = rr_ptr_reg;
        gnt_next      = gnt_reg;
        beat_cnt_next = beat_cnt_reg;
        rvalid_next   = '0;
        case (state_reg)
            S_IDLE: begin
                if (found) begin
                    state_next         = S_GRANT;
                    owner_next         = winner;
                    gnt_next           = '0;
                    gnt_next[winner]   = 1'b1;
                    beat_cnt_next      = '0;
                end
            end
            S_GRANT: begin
                if (!own_req || own_last || (cnt_inc == MAX_CNT)) begin
                    state_next    = S_IDLE;
                    gnt_next      = '0;
                    beat_cnt_next = '0;
                    rr_ptr_next   = (owner_reg == LAST_IDX) ? '0 : owner_reg + IW'(1);
                end else begin
                    beat_cnt_next = cnt_inc;
                end
                // Read return is tagged by the beat itself, so it survives a release at t.
                if (own_req && !own_wr) begin
                    rvalid_next[owner_reg] = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_reg    <= S_IDLE;
            owner_reg    <= '0;
            rr_ptr_reg   <= '0;
            gnt_reg      <= '0;
            rvalid_reg   <= '0;
            beat_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            owner_reg    <= owner_next;
            rr_ptr_reg   <= rr_ptr_next;
            gnt_reg      <= gnt_next;
            rvalid_reg   <= rvalid_next;
            beat_cnt_reg <= beat_cnt_next;
        end
    end

endmodule

// File: tb/tb_spmv_sram_arbiter.sv
// Self-checking bench for spmv_sram_arbiter: behavioural SRAM, shadow memory model and
// a read-return scoreboard filled when each beat is driven.
module tb_spmv_sram_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 256;
    localparam logic [DW-1:0] ROW_A5 = {32{8'hA5}};

    logic               i_clk  = 1'b0;
    logic               i_rstn = 1'b0;
    logic [NREQ-1:0]    req, last, wr;
    logic [AW-1:0]      addr_arr  [NREQ];
    logic [DW-1:0]      wdata_arr [NREQ];
    logic [NREQ*AW-1:0] i_addr;
    logic [NREQ*DW-1:0] i_wdata;
    logic [NREQ-1:0]    o_gnt, o_rvalid;
    logic [AW-1:0]      o_address;
    logic               o_wr_en, o_busy;
    logic [DW-1:0]      o_write_data, o_rdata;
    logic [DW-1:0]      i_read_data = '0;

    logic [DW-1:0]      sram    [32] = '{default: '0};
    logic [DW-1:0]      exp_mem [32];
    int                 sb_k [$];
    logic [DW-1:0]      sb_d [$];
    int                 n_checks = 0;
    int                 n_errors = 0;
    int                 mon_k;
    logic [DW-1:0]      mon_d;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_pack
            assign i_addr[gi*AW +: AW]  = addr_arr[gi];
            assign i_wdata[gi*DW +: DW] = wdata_arr[gi];
        end
    endgenerate

    spmv_sram_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .MAX_BURST(8)) dut (
        .i_clk        (i_clk),
        .i_rstn       (i_rstn),
        .i_req        (req),
        .i_last       (last),
        .i_wr_en      (wr),
        .i_addr       (i_addr),
        .i_wdata      (i_wdata),
        .o_gnt        (o_gnt),
        .o_address    (o_address),
        .o_wr_en      (o_wr_en),
        .o_write_data (o_write_data),
        .i_read_data  (i_read_data),
        .o_rvalid     (o_rvalid),
        .o_rdata      (o_rdata),
        .o_busy       (o_busy)
    );

    always #5 i_clk = ~i_clk;

    // Behavioural single-port SRAM, 1-cycle read latency; row 7 preloaded while in reset.
    always @(posedge i_clk) begin
        if (!i_rstn) sram[7] <= ROW_A5;
        else if (o_wr_en) sram[o_address] <= o_write_data;
        i_read_data <= sram[o_address];
    end

    always @(negedge i_clk) begin
        if (i_rstn && o_rvalid !== '0) begin
            n_checks++;
            if (sb_k.size() == 0) begin
                n_errors++;
                $display("FAIL rvalid_unexpected: got rvalid=%b, required none", o_rvalid);
            end else begin
                mon_k = sb_k.pop_front();
                mon_d = sb_d.pop_front();
                if (o_rvalid !== 3'(1 << mon_k) || o_rdata !== mon_d) begin
                    n_errors++;
                    $display("FAIL read_return: got rvalid=%b rdata=%h, required rvalid=%b rdata=%h",
                             o_rvalid, o_rdata, 3'(1 << mon_k), mon_d);
                end
            end
        end
    end

    function automatic logic [DW-1:0] mk(input int tag);
        mk = {8{tag[15:0], 16'hBEEF}};
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_inputs();
        req  = '0;
        last = '0;
        wr   = '0;
        for (int k = 0; k < NREQ; k++) begin
            addr_arr[k]  = '0;
            wdata_arr[k] = '0;
        end
    endtask

    task automatic drive(input int k, input logic w, input int a, input logic [DW-1:0] d,
                         input logic l);
        req[k]       = 1'b1;
        wr[k]        = w;
        addr_arr[k]  = AW'(a);
        wdata_arr[k] = d;
        last[k]      = l;
    endtask

    // Record the beat requester k is presenting now as accepted by the SRAM.
    task automatic accept(input int k);
        if (wr[k]) begin
            exp_mem[addr_arr[k]] = wdata_arr[k];
        end else begin
            sb_k.push_back(k);
            sb_d.push_back(exp_mem[addr_arr[k]]);
        end
        $display("txn req%0d %s addr=%0d last=%0b data=%h", k, wr[k] ? "wr" : "rd",
                 addr_arr[k], last[k], wr[k] ? wdata_arr[k] : exp_mem[addr_arr[k]]);
    endtask

    task automatic test_reset();
        clear_inputs();
        i_rstn = 1'b0;
        repeat (2) tick();
        n_checks++;
        if (o_gnt !== 3'b000 || o_busy !== 1'b0 || o_rvalid !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_ctrl: got gnt=%b busy=%b rvalid=%b, required 000 0 000",
                     o_gnt, o_busy, o_rvalid);
        end
        n_checks++;
        if (o_address !== '0 || o_wr_en !== 1'b0 || o_write_data !== '0) begin
            n_errors++;
            $display("FAIL reset_sram: got addr=%0d we=%b wdata=%h, required 0 0 0",
                     o_address, o_wr_en, o_write_data);
        end
        @(negedge i_clk) i_rstn = 1'b1;
        tick();
        // Move the rr pointer away from 0 (req1 burst -> pointer 2).
        drive(1, 1'b1, 10, mk(10), 1'b1);
        tick();
        n_checks++;
        if (o_gnt !== 3'b010) begin
            n_errors++;
            $display("FAIL reset_pre_grant1: got gnt=%b, required 010", o_gnt);
        end
        accept(1);
        tick();
        req[1] = 1'b0;
        drive(2, 1'b1, 11, mk(11), 1'b0);
        tick();
        n_checks++;
        if (o_gnt !== 3'b100 || o_wr_en !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_pre_grant2: got gnt=%b we=%b, required 100 1", o_gnt, o_wr_en);
        end
        #2;
        i_rstn = 1'b0;
        #1;
        n_checks++;
        if (o_wr_en !== 1'b0 || o_gnt !== 3'b000 || o_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_async_kill: got we=%b gnt=%b busy=%b, required 0 000 0",
                     o_wr_en, o_gnt, o_busy);
        end
        clear_inputs();
        repeat (2) tick();
        n_checks++;
        if (sram[11] !== '0) begin
            n_errors++;
            $display("FAIL reset_killed_write: got row11=%h, required 0", sram[11]);
        end
        @(negedge i_clk) i_rstn = 1'b1;
        drive(0, 1'b0, 0, '0, 1'b1);
        drive(1, 1'b0, 0, '0, 1'b1);
        drive(2, 1'b0, 0, '0, 1'b1);
        tick();
        n_checks++;
        if (o_gnt !== 3'b001) begin
            n_errors++;
            $display("FAIL reset_first_grant: got gnt=%b, required 001", o_gnt);
        end
        accept(0);
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_single_read();
        drive(1, 1'b0, 7, '0, 1'b1);
        tick();
        n_checks++;
        if (o_gnt !== 3'b010 || o_busy !== 1'b1 || o_address !== 5'd7 || o_wr_en !== 1'b0) begin
            n_errors++;
            $display("FAIL single_read_grant: got gnt=%b busy=%b addr=%0d we=%b, required 010 1 7 0",
                     o_gnt, o_busy, o_address, o_wr_en);
        end
        accept(1);
        tick();
        n_checks++;
        if (o_gnt !== 3'b000 || o_rvalid !== 3'b010 || o_rdata !== ROW_A5) begin
            n_errors++;
            $display("FAIL single_read_data: got gnt=%b rvalid=%b rdata=%h, required 000 010 %h",
                     o_gnt, o_rvalid, o_rdata, ROW_A5);
        end
        clear_inputs();
        tick();
        n_checks++;
        if (o_rvalid !== 3'b000) begin
            n_errors++;
            $display("FAIL single_read_rvalid_clear: got rvalid=%b, required 000", o_rvalid);
        end
    endtask

    task automatic test_forced_release();
        drive(2, 1'b1, 16, mk(200), 1'b0);
        tick();
        n_checks++;
        if (o_gnt !== 3'b100) begin
            n_errors++;
            $display("FAIL forced_grant: got gnt=%b, required 100", o_gnt);
        end
        for (int b = 0; b < 10; b++) begin
            drive(2, 1'b1, 16 + b, mk(200 + b), (b == 9));
            #1;
            accept(2);
            n_checks++;
            if (o_address !== AW'(16 + b) || o_wr_en !== 1'b1 || o_write_data !== mk(200 + b)) begin
                n_errors++;
                $display("FAIL forced_beat%0d: got addr=%0d we=%b wdata=%h, required %0d 1 %h",
                         b, o_address, o_wr_en, o_write_data, 16 + b, mk(200 + b));
            end
            tick();
            if (b == 7) begin
                n_checks++;
                if (o_gnt !== 3'b000) begin
                    n_errors++;
                    $display("FAIL forced_release: got gnt=%b after beat 8, required 000", o_gnt);
                end
                tick();
                n_checks++;
                if (o_gnt !== 3'b100) begin
                    n_errors++;
                    $display("FAIL forced_regrant: got gnt=%b, required 100", o_gnt);
                end
            end
        end
        n_checks++;
        if (o_gnt !== 3'b000) begin
            n_errors++;
            $display("FAIL forced_final_release: got gnt=%b, required 000", o_gnt);
        end
        clear_inputs();
        tick();
        for (int b = 0; b < 10; b++) begin
            n_checks++;
            if (sram[16 + b] !== exp_mem[16 + b]) begin
                n_errors++;
                $display("FAIL forced_row%0d: got %h, required %h", 16 + b, sram[16 + b],
                         exp_mem[16 + b]);
            end
        end
    endtask

    task automatic test_round_robin();
        int ek;
        for (int k = 0; k < NREQ; k++) drive(k, 1'b1, 0, mk(300 + 10*k), 1'b0);
        tick();
        for (int g = 0; g < 4; g++) begin
            ek = g % NREQ;
            n_checks++;
            if (o_gnt !== 3'(1 << ek) || o_busy !== 1'b1) begin
                n_errors++;
                $display("FAIL rr_grant%0d: got gnt=%b busy=%b, required %b 1",
                         g, o_gnt, o_busy, 3'(1 << ek));
            end
            accept(ek);
            n_checks++;
            if (o_address !== 5'd0 || o_wr_en !== 1'b1 || o_write_data !== wdata_arr[ek]) begin
                n_errors++;
                $display("FAIL rr_beat0_g%0d: got addr=%0d we=%b wdata=%h, required 0 1 %h",
                         g, o_address, o_wr_en, o_write_data, wdata_arr[ek]);
            end
            tick();
            drive(ek, 1'b1, 1, mk(400 + g), 1'b1);
            #1;
            accept(ek);
            n_checks++;
            if (o_address !== 5'd1 || o_write_data !== mk(400 + g)) begin
                n_errors++;
                $display("FAIL rr_beat1_g%0d: got addr=%0d wdata=%h, required 1 %h",
                         g, o_address, o_write_data, mk(400 + g));
            end
            tick();
            n_checks++;
            if (o_gnt !== 3'b000 || o_busy !== 1'b0) begin
                n_errors++;
                $display("FAIL rr_dead_cycle%0d: got gnt=%b busy=%b, required 000 0",
                         g, o_gnt, o_busy);
            end
            if (g == 3) clear_inputs();
            else drive(ek, 1'b1, 0, mk(500 + g), 1'b0);
            tick();
        end
        n_checks++;
        if (o_gnt !== 3'b000) begin
            n_errors++;
            $display("FAIL rr_idle_after: got gnt=%b, required 000", o_gnt);
        end
        for (int a = 0; a < 2; a++) begin
            n_checks++;
            if (sram[a] !== exp_mem[a]) begin
                n_errors++;
                $display("FAIL rr_row%0d: got %h, required %h", a, sram[a], exp_mem[a]);
            end
        end
    endtask

    task automatic test_abandon();
        drive(0, 1'b1, 26, mk(26), 1'b0);
        tick();
        n_checks++;
        if (o_gnt !== 3'b001) begin
            n_errors++;
            $display("FAIL abandon_grant: got gnt=%b, required 001", o_gnt);
        end
        accept(0);
        tick();
        req[0]       = 1'b0;
        addr_arr[0]  = 5'd27;
        wdata_arr[0] = mk(27);
        #1;
        n_checks++;
        if (o_wr_en !== 1'b0 || o_address !== '0 || o_write_data !== '0 || o_gnt !== 3'b001) begin
            n_errors++;
            $display("FAIL abandon_dropped_cycle: got we=%b addr=%0d wdata=%h gnt=%b, required 0 0 0 001",
                     o_wr_en, o_address, o_write_data, o_gnt);
        end
        tick();
        n_checks++;
        if (o_gnt !== 3'b000 || o_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL abandon_release: got gnt=%b busy=%b, required 000 0", o_gnt, o_busy);
        end
        drive(0, 1'b0, 26, '0, 1'b1);
        drive(1, 1'b0, 26, '0, 1'b1);
        tick();
        n_checks++;
        if (o_gnt !== 3'b010) begin
            n_errors++;
            $display("FAIL abandon_rr_ptr: got gnt=%b, required 010", o_gnt);
        end
        accept(1);
        tick();
        clear_inputs();
        tick();
        n_checks++;
        if (sram[27] !== '0) begin
            n_errors++;
            $display("FAIL abandon_no_write: got row27=%h, required 0", sram[27]);
        end
    endtask

    task automatic test_back_to_back();
        drive(1, 1'b0, 3, '0, 1'b0);
        tick();
        n_checks++;
        if (o_gnt !== 3'b010 || o_wr_en !== 1'b0 || o_address !== 5'd3) begin
            n_errors++;
            $display("FAIL b2b_read_beat: got gnt=%b we=%b addr=%0d, required 010 0 3",
                     o_gnt, o_wr_en, o_address);
        end
        accept(1);
        tick();
        n_checks++;
        if (o_rvalid !== 3'b010) begin
            n_errors++;
            $display("FAIL b2b_rvalid_read: got rvalid=%b, required 010", o_rvalid);
        end
        drive(1, 1'b1, 3, DW'(1), 1'b1);
        #1;
        accept(1);
        n_checks++;
        if (o_wr_en !== 1'b1 || o_write_data !== DW'(1)) begin
            n_errors++;
            $display("FAIL b2b_write_beat: got we=%b wdata=%h, required 1 1", o_wr_en, o_write_data);
        end
        tick();
        n_checks++;
        if (o_rvalid !== 3'b000 || o_gnt !== 3'b000) begin
            n_errors++;
            $display("FAIL b2b_after_write: got rvalid=%b gnt=%b, required 000 000", o_rvalid, o_gnt);
        end
        clear_inputs();
        tick();
        drive(1, 1'b0, 3, '0, 1'b1);
        tick();
        accept(1);
        tick();
        n_checks++;
        if (o_rvalid !== 3'b010 || o_rdata !== DW'(1)) begin
            n_errors++;
            $display("FAIL b2b_readback: got rvalid=%b rdata=%h, required 010 1", o_rvalid, o_rdata);
        end
        clear_inputs();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        for (int i = 0; i < 32; i++) exp_mem[i] = '0;
        exp_mem[7] = ROW_A5;
        test_reset();
        test_single_read();
        test_forced_release();
        test_round_robin();
        test_abandon();
        test_back_to_back();
        repeat (2) tick();
        n_checks++;
        if (sb_k.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d pending reads, required 0", sb_k.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
